// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged reset release after PLL lock, with lock-loss filtering
// Releases rst_out bits in order once lock has been stable; re-asserts them all together.
module reset_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 1024,
  parameter int STAGE_GAP   = 64,
  parameter int NUM_STAGES  = 3,
  parameter int LOCK_FILTER = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pll_lock,
  input  logic                  sw_reset,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  ready,
  output logic [2:0]            state_dbg,
  output logic [7:0]            lost_count
);

  localparam int CNT_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int GAP_W  = (STAGE_GAP > 1)   ? $clog2(STAGE_GAP)   : 1;
  localparam int FILT_W = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP - 1);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILTER - 1);

  typedef enum logic [2:0] {
    ST_ASSERT    = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_HOLD      = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] rst_sync;
  logic [SYNC_STAGES-1:0] lock_sync;
  logic [CNT_W-1:0]       cnt;
  logic [GAP_W-1:0]       gap;
  logic [FILT_W-1:0]      filt;
  logic                   rst_s;
  logic                   lock_s;
  logic                   lock_lost;

  assign rst_s     = rst_sync[SYNC_STAGES-1];
  assign lock_s    = lock_sync[SYNC_STAGES-1];
  assign state_dbg = state;
  assign lock_lost = ((state == ST_RELEASE) || (state == ST_RUN)) && !lock_s && (filt == FILT_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rst_sync   <= '1;
      lock_sync  <= '0;
      state      <= ST_ASSERT;
      rst_out    <= '1;
      ready      <= 1'b0;
      lost_count <= 8'd0;
      cnt        <= '0;
      gap        <= '0;
      filt       <= '0;
    end else begin
      rst_sync  <= {rst_sync[SYNC_STAGES-2:0], 1'b0};
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_lock};
      case (state)
        ST_ASSERT: begin
          rst_out <= '1;
          ready   <= 1'b0;
          cnt     <= '0;
          gap     <= '0;
          filt    <= '0;
          if (!rst_s) state <= ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state <= ST_HOLD;
            cnt   <= '0;
          end
        end
        ST_HOLD: begin
          if (!lock_s) begin
            state <= ST_WAIT_LOCK;
            cnt   <= '0;
          end else if (sw_reset) begin
            cnt <= '0;
          end else if (cnt == HOLD_LAST) begin
            state   <= ST_RELEASE;
            rst_out <= rst_out << 1;
            gap     <= '0;
            filt    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RELEASE, ST_RUN: begin
          if (lock_lost || sw_reset) begin
            state   <= ST_ASSERT;
            rst_out <= '1;
            ready   <= 1'b0;
            cnt     <= '0;
            gap     <= '0;
            filt    <= '0;
            if (lock_lost && (lost_count != 8'hFF)) lost_count <= lost_count + 8'd1;
          end else begin
            filt <= lock_s ? '0 : filt + 1'b1;
            if (state == ST_RUN) begin
              ready <= 1'b1;
            end else if (rst_out[NUM_STAGES-1] == 1'b0) begin
              // only reachable with a single stage, already released on HOLD exit
              state <= ST_RUN;
            end else if (gap == GAP_LAST) begin
              rst_out <= rst_out << 1;
              gap     <= '0;
              if ((rst_out << 1) == '0) state <= ST_RUN;
            end else begin
              gap <= gap + 1'b1;
            end
          end
        end
        default: state <= ST_ASSERT;
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - scoreboard bench for reset_sequencer
// Expected output changes are queued with their edge number; the monitor pops one per observed change.
module tb_reset_sequencer;

  logic       clock;
  logic       reset;
  logic       pll_lock;
  logic       sw_reset;
  logic [2:0] rst_out;
  logic       ready;
  logic [2:0] state_dbg;
  logic [7:0] lost_count;

  logic       pll_lock2;
  logic       sw_reset2;
  logic [0:0] rst_out2;
  logic       ready2;
  logic [2:0] state2;
  logic [7:0] lost2;

  int n_chk;
  int n_fail;
  int edge_cnt;
  bit mon_en;

  typedef struct {
    int         at;
    logic [2:0] st;
    logic [2:0] ro;
    logic       rdy;
    logic [7:0] lost;
  } exp_t;

  exp_t exp_q[$];

  reset_sequencer dut (
    .clock(clock), .reset(reset), .pll_lock(pll_lock), .sw_reset(sw_reset),
    .rst_out(rst_out), .ready(ready), .state_dbg(state_dbg), .lost_count(lost_count)
  );

  reset_sequencer #(
    .SYNC_STAGES(2), .HOLD_CYCLES(2), .STAGE_GAP(1), .NUM_STAGES(1), .LOCK_FILTER(1)
  ) dut_small (
    .clock(clock), .reset(reset), .pll_lock(pll_lock2), .sw_reset(sw_reset2),
    .rst_out(rst_out2), .ready(ready2), .state_dbg(state2), .lost_count(lost2)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  // Monitor: every change of the output tuple must match the head of the queue.
  logic [14:0] prev_obs = 'x;
  always @(negedge clock) begin
    logic [14:0] cur;
    exp_t e;
    cur = {state_dbg, rst_out, ready, lost_count};
    if (mon_en && (cur !== prev_obs)) begin
      prev_obs = cur;
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_change: edge %0d st %0d rst %b rdy %b lost %0d, required no change",
                 edge_cnt, state_dbg, rst_out, ready, lost_count);
      end else begin
        e = exp_q.pop_front();
        if (((e.at >= 0) && (e.at != edge_cnt)) || (state_dbg !== e.st) || (rst_out !== e.ro) ||
            (ready !== e.rdy) || (lost_count !== e.lost)) begin
          n_fail++;
          $display("FAIL event: edge %0d st %0d rst %b rdy %b lost %0d, required edge %0d st %0d rst %b rdy %b lost %0d",
                   edge_cnt, state_dbg, rst_out, ready, lost_count, e.at, e.st, e.ro, e.rdy, e.lost);
        end
      end
    end
  end

  task automatic push(input int at, input logic [2:0] st, input logic [2:0] ro, input logic rdy, input logic [7:0] lost);
    exp_t e;
    e.at = at; e.st = st; e.ro = ro; e.rdy = rdy; e.lost = lost;
    exp_q.push_back(e);
  endtask

  // Release events following a HOLD (re)start whose counter reads 0 after edge h.
  task automatic push_release(input int h, input logic [7:0] lost);
    push(h + 1024, 3'd3, 3'b110, 1'b0, lost);
    push(h + 1088, 3'd3, 3'b100, 1'b0, lost);
    push(h + 1152, 3'd4, 3'b000, 1'b0, lost);
    push(h + 1153, 3'd4, 3'b000, 1'b1, lost);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic step_to(input int e);
    step(e - edge_cnt);
  endtask

  task automatic drain(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) step(1);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d events pending, required 0", name, exp_q.size());
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic wait_small(input bit want_ready, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step(1);
      if (want_ready ? (ready2 === 1'b1) : (state2 === 3'd0)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int b, a, s, h, x, h2, z;
    bit ok;
    n_chk = 0; n_fail = 0; edge_cnt = 0; mon_en = 1'b1;
    reset = 1'b1; pll_lock = 1'b1; sw_reset = 1'b0;
    pll_lock2 = 1'b0; sw_reset2 = 1'b0;
    push(-1, 3'd0, 3'b111, 1'b0, 8'd0);

    // power-up sequence
    step(3);
    reset = 1'b0;
    b = edge_cnt;
    push(b + 3, 3'd1, 3'b111, 1'b0, 8'd0);
    push(b + 4, 3'd2, 3'b111, 1'b0, 8'd0);
    push_release(b + 4, 8'd0);
    drain("power_up", 1300);
    step(5);

    // short lock dropout is filtered
    pll_lock = 1'b0;
    step(7);
    pll_lock = 1'b1;
    step(20);

    // long lock dropout re-sequences
    a = edge_cnt;
    push(a + 10, 3'd0, 3'b111, 1'b0, 8'd1);
    push(a + 11, 3'd1, 3'b111, 1'b0, 8'd1);
    push(a + 13, 3'd2, 3'b111, 1'b0, 8'd1);
    push_release(a + 13, 8'd1);
    pll_lock = 1'b0;
    step(10);
    pll_lock = 1'b1;
    drain("lock_loss", 1300);
    step(5);

    // sw_reset in RUN, lock glitch in HOLD, sw_reset in HOLD
    s = edge_cnt;
    h = s + 3;
    x = h + 500;
    h2 = x + 4;
    z = h2 + 100;
    push(s + 1, 3'd0, 3'b111, 1'b0, 8'd1);
    push(s + 2, 3'd1, 3'b111, 1'b0, 8'd1);
    push(h, 3'd2, 3'b111, 1'b0, 8'd1);
    push(x + 3, 3'd1, 3'b111, 1'b0, 8'd1);
    push(h2, 3'd2, 3'b111, 1'b0, 8'd1);
    push(z + 1024, 3'd3, 3'b110, 1'b0, 8'd1);
    push(z + 1088, 3'd3, 3'b100, 1'b0, 8'd1);
    sw_reset = 1'b1;
    step(1);
    sw_reset = 1'b0;
    step_to(x);
    pll_lock = 1'b0;
    step(1);
    pll_lock = 1'b1;
    step_to(h2 + 99);
    sw_reset = 1'b1;
    step(1);
    sw_reset = 1'b0;

    // async reset mid-release, then a fresh sequence
    step_to(z + 1098);
    push(edge_cnt, 3'd0, 3'b111, 1'b0, 8'd0);
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    b = edge_cnt;
    push(b + 3, 3'd1, 3'b111, 1'b0, 8'd0);
    push(b + 4, 3'd2, 3'b111, 1'b0, 8'd0);
    push_release(b + 4, 8'd0);
    drain("async_reset", 1300);
    step(5);

    // sw_reset coinciding with filtered lock loss still counts the loss
    a = edge_cnt;
    push(a + 10, 3'd0, 3'b111, 1'b0, 8'd1);
    push(a + 11, 3'd1, 3'b111, 1'b0, 8'd1);
    push(a + 13, 3'd2, 3'b111, 1'b0, 8'd1);
    pll_lock = 1'b0;
    step(9);
    sw_reset = 1'b1;
    step(1);
    sw_reset = 1'b0;
    pll_lock = 1'b1;
    drain("sw_and_loss", 40);
    mon_en = 1'b0;

    // lost_count saturation on the single-stage instance
    for (int i = 1; i <= 300; i++) begin
      pll_lock2 = 1'b1;
      wait_small(1'b1, ok);
      n_chk++;
      if (!ok) begin
        n_fail++;
        $display("FAIL small_run_timeout: iteration %0d, ready %b, required 1", i, ready2);
        break;
      end
      if (i == 1) check8("small_rst_out", {7'd0, rst_out2}, 8'd0);
      pll_lock2 = 1'b0;
      wait_small(1'b0, ok);
      n_chk++;
      if (!ok) begin
        n_fail++;
        $display("FAIL small_loss_timeout: iteration %0d, state %0d, required 0", i, state2);
        break;
      end
      if (i == 1)   check8("lost_1", lost2, 8'd1);
      if (i == 254) check8("lost_254", lost2, 8'd254);
      if (i == 255) check8("lost_255", lost2, 8'd255);
      if (i == 300) check8("lost_sat", lost2, 8'd255);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
